ad_fifo_ctrl: RTL and testbench
===============================

Name: ad_fifo_ctrl

Overview:
Sequencing controller for the USB2 data-recovery add/drop FIFO. Filters early/late phase indications from the edge detector and issues single-cycle Add/Drop corrections with a hold-off between them. Generates the per-cycle CRD read strobe and a FIFO reset pulse for initial centring and recovery. Tracks net correction offset, error count and lock status for the recovery block.

Parameters:
FILT_W, 4, width of signed phase-filter accumulator
THRESH, 6, filter magnitude that triggers a correction (must be < 2^(FILT_W-1))
HOLDOFF, 3, cycles spent in HOLD after each correction
RESYNC_CYCLES, 8, cycles FifoReset is held high in RESYNC
MAX_OFFSET, 20, saturation limit of net offset (equals half the FIFO depth)
LOCK_CYCLES, 16, correction-free TRACK/HOLD cycles required before Locked

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous active-high reset
Enable  in  1  run request; 0 forces IDLE
Early  in  1  phase detector: data early
Late  in  1  phase detector: data late
Underflow  in  1  FIFO underflow flag
Overflow  in  1  FIFO overflow flag
CRD  out  1  FIFO read/shift strobe
Add  out  1  one-cycle add pulse to FIFO
Drop  out  1  one-cycle drop pulse to FIFO
FifoReset  out  1  FIFO reset request
Offset  out  8  signed net corrections (Add +1, Drop -1)
ErrCount  out  8  saturating count of under/overflow events
Locked  out  1  tracking stable

Behaviour:
- Clock is the only clock; Reset is asynchronous, active-high. While Reset is high: state=IDLE; all outputs, filter and counters are 0.
- All outputs are registered.
- States: IDLE, RESYNC, TRACK, HOLD (plus FAULT, see Optional Feature).
- Enable=0 in any state: IDLE on the next edge; CRD/Add/Drop/FifoReset/Locked=0; Offset and ErrCount hold their values.
- IDLE -> RESYNC when Enable=1.
- RESYNC: FifoReset=1 for exactly RESYNC_CYCLES cycles; filter, Offset and lock counter cleared; CRD=0; then TRACK.
- TRACK: CRD=1 every cycle.
  - Early&!Late: filter +1. Late&!Early: filter -1. Both or neither: filter holds.
  - If the updated filter equals +THRESH: Add=1 on the next cycle, Offset +1, filter cleared, go to HOLD.
  - If the updated filter equals -THRESH: Drop=1 on the next cycle, Offset -1, filter cleared, go to HOLD.
  - Add and Drop are never both high.
- Offset saturation: if Offset is already +MAX_OFFSET, an Add is suppressed; at -MAX_OFFSET, a Drop is suppressed. The filter still clears and the FSM still enters HOLD.
- HOLD: CRD=1; Early and Late are ignored; filter frozen; returns to TRACK after HOLDOFF cycles.
- Underflow or Overflow sampled high in TRACK or HOLD:
  - ErrCount +1, saturating at 255.
  - Go to RESYNC.
  - Any Add/Drop decided in the same cycle is suppressed; the error takes priority.
- Lock counter:
  - Increments each TRACK/HOLD cycle.
  - Cleared on Add/Drop issue, RESYNC entry or IDLE.
  - Locked=1 once the count reaches LOCK_CYCLES; the counter saturates there.
- Latency: a filter threshold crossing on edge n gives an Add/Drop pulse during cycle n+1. An error flag at edge n gives FifoReset=1 from cycle n+1.

Optional Feature:
AD_FIFO_CTRL_STICKY_ERR_EN
- Defined: Underflow/Overflow in TRACK or HOLD moves the FSM to FAULT, with ErrCount still incremented. In FAULT: CRD/Add/Drop=0, FifoReset=1, Locked=0. FAULT is left only via Enable=0 (to IDLE) or Reset.
- Undefined: no FAULT state; errors auto-resync as described above.

Test Plan:
1. Reset then Enable=1 -> FifoReset high for exactly 8 cycles, then CRD=1 continuously; Offset=0, Locked=1 after 16 further quiet cycles.
2. In TRACK, Early=1 for 6 consecutive cycles -> a single Add pulse in the cycle after the 6th; Offset=1; next 3 cycles ignore Early; filter restarts from 0.
3. Alternate Early/Late, and also drive Early=Late=1 -> no Add/Drop ever; Locked stays 1.
4. Sustained Late for 30 corrections -> Offset stops at -20; later Drops are suppressed while HOLD is still entered.
5. Overflow pulse in the same cycle the filter hits +6 -> no Add; ErrCount=1; FifoReset high for 8 cycles; Offset=0; Locked=0. With AD_FIFO_CTRL_STICKY_ERR_EN: FSM stays in FAULT until Enable is toggled.
6. Reset asserted mid-HOLD, asynchronously -> all outputs 0 immediately; after release with Enable=1 -> RESYNC sequence restarts.

Source files
------------

// File: rtl/ad_fifo_ctrl.sv
// Add/drop FIFO sequencer for USB2 data recovery: phase filter, Add/Drop pulses, CRD strobe, FIFO reset.
// Latency: all outputs registered, corrections/resync visible the cycle after the deciding edge; no backpressure.
// Optional: AD_FIFO_CTRL_STICKY_ERR_EN parks the FSM in FAULT after an under/overflow until Enable drops.
module ad_fifo_ctrl #(
    parameter int FILT_W        = 4,
    parameter int THRESH        = 6,
    parameter int HOLDOFF       = 3,
    parameter int RESYNC_CYCLES = 8,
    parameter int MAX_OFFSET    = 20,
    parameter int LOCK_CYCLES   = 16
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Enable,
    input  logic       Early,
    input  logic       Late,
    input  logic       Underflow,
    input  logic       Overflow,
    output logic       CRD,
    output logic       Add,
    output logic       Drop,
    output logic       FifoReset,
    output logic [7:0] Offset,
    output logic [7:0] ErrCount,
    output logic       Locked
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RESYNC = 3'd1,
        S_TRACK  = 3'd2,
        S_HOLD   = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    localparam int STEP_MAX = (RESYNC_CYCLES > HOLDOFF) ? RESYNC_CYCLES : HOLDOFF;
    localparam int STEP_W   = $clog2(STEP_MAX + 1);
    localparam int LOCK_W   = $clog2(LOCK_CYCLES + 1);

    localparam logic [STEP_W-1:0]        RESYNC_LAST = STEP_W'(RESYNC_CYCLES - 1);
    localparam logic [STEP_W-1:0]        HOLD_LAST   = STEP_W'(HOLDOFF - 1);
    localparam logic [STEP_W-1:0]        STEP_ONE    = STEP_W'(1);
    localparam logic [LOCK_W-1:0]        LOCK_FULL   = LOCK_W'(LOCK_CYCLES);
    localparam logic [LOCK_W-1:0]        LOCK_ONE    = LOCK_W'(1);
    localparam logic signed [FILT_W-1:0] FILT_POS    = FILT_W'(THRESH);
    localparam logic signed [FILT_W-1:0] FILT_NEG    = FILT_W'(-THRESH);
    localparam logic signed [FILT_W-1:0] FILT_ONE    = FILT_W'(1);
    localparam logic [7:0]               OFF_POS     = 8'(MAX_OFFSET);
    localparam logic [7:0]               OFF_NEG     = 8'(-MAX_OFFSET);

`ifdef AD_FIFO_CTRL_STICKY_ERR_EN
    localparam state_t ERR_DEST = S_FAULT;
`else
    localparam state_t ERR_DEST = S_RESYNC;
`endif

    state_t                   state_q, state_d;
    logic [STEP_W-1:0]        step_q, step_d;
    logic [LOCK_W-1:0]        lock_q, lock_d;
    logic signed [FILT_W-1:0] filt_q, filt_d, filt_upd;
    logic [7:0]               offset_d, errcnt_d;
    logic                     crd_d, add_d, drop_d, fifo_reset_d, locked_d;

    logic track_or_hold, err_evt, hit_pos, hit_neg, add_go, drop_go;

    always_comb begin
        filt_upd = filt_q;
        if (Early && !Late) begin
            filt_upd = filt_q + FILT_ONE;
        end else if (Late && !Early) begin
            filt_upd = filt_q - FILT_ONE;
        end
    end

    // A saturated offset suppresses the pulse but the crossing still counts as a correction for the FSM.
    always_comb begin
        track_or_hold = (state_q == S_TRACK) || (state_q == S_HOLD);
        err_evt       = track_or_hold && (Underflow || Overflow);
        hit_pos       = (state_q == S_TRACK) && (filt_upd == FILT_POS);
        hit_neg       = (state_q == S_TRACK) && (filt_upd == FILT_NEG);
        add_go        = Enable && hit_pos && !err_evt && (Offset != OFF_POS);
        drop_go       = Enable && hit_neg && !err_evt && (Offset != OFF_NEG);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            lock_q    <= '0;
            filt_q    <= '0;
            CRD       <= 1'b0;
            Add       <= 1'b0;
            Drop      <= 1'b0;
            FifoReset <= 1'b0;
            Offset    <= 8'd0;
            ErrCount  <= 8'd0;
            Locked    <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            lock_q    <= lock_d;
            filt_q    <= filt_d;
            CRD       <= crd_d;
            Add       <= add_d;
            Drop      <= drop_d;
            FifoReset <= fifo_reset_d;
            Offset    <= offset_d;
            ErrCount  <= errcnt_d;
            Locked    <= locked_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!Enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   state_d = S_RESYNC;
                S_RESYNC: if (step_q == RESYNC_LAST) state_d = S_TRACK;
                S_TRACK: begin
                    if (err_evt) begin
                        state_d = ERR_DEST;
                    end else if (hit_pos || hit_neg) begin
                        state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (err_evt) begin
                        state_d = ERR_DEST;
                    end else if (step_q == HOLD_LAST) begin
                        state_d = S_TRACK;
                    end
                end
                S_FAULT:  state_d = S_FAULT;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are computed from the next state so that every output leaves a flop.
    always_comb begin
        crd_d        = (state_d == S_TRACK) || (state_d == S_HOLD);
        fifo_reset_d = (state_d == S_RESYNC) || (state_d == S_FAULT);
        add_d        = add_go;
        drop_d       = drop_go;

        step_d = '0;
        if ((state_d == state_q) && ((state_q == S_RESYNC) || (state_q == S_HOLD))) begin
            step_d = step_q + STEP_ONE;
        end

        filt_d = filt_q;
        if (state_d == S_RESYNC) begin
            filt_d = '0;
        end else if ((state_q == S_TRACK) && (state_d == S_TRACK)) begin
            filt_d = filt_upd;
        end else if ((state_q == S_TRACK) && (state_d == S_HOLD)) begin
            filt_d = '0;
        end

        lock_d = '0;
        if (track_or_hold && ((state_d == S_TRACK) || (state_d == S_HOLD))) begin
            if (add_go || drop_go) begin
                lock_d = '0;
            end else if (lock_q != LOCK_FULL) begin
                lock_d = lock_q + LOCK_ONE;
            end else begin
                lock_d = lock_q;
            end
        end
        locked_d = (lock_d == LOCK_FULL);

        offset_d = Offset;
        if (state_d == S_RESYNC) begin
            offset_d = 8'd0;
        end else if (add_go) begin
            offset_d = Offset + 8'd1;
        end else if (drop_go) begin
            offset_d = Offset - 8'd1;
        end

        errcnt_d = ErrCount;
        if (Enable && err_evt && (ErrCount != 8'hFF)) begin
            errcnt_d = ErrCount + 8'd1;
        end
    end

endmodule

// File: tb/tb_ad_fifo_ctrl.sv
// Directed bench for ad_fifo_ctrl: startup, corrections, saturation, error resync and async reset.
module tb_ad_fifo_ctrl;

    logic       Clock = 1'b0;
    logic       Reset, Enable, Early, Late, Underflow, Overflow;
    logic       CRD, Add, Drop, FifoReset, Locked;
    logic [7:0] Offset, ErrCount;

    int errors = 0;
    int checks = 0;

    ad_fifo_ctrl dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Enable    (Enable),
        .Early     (Early),
        .Late      (Late),
        .Underflow (Underflow),
        .Overflow  (Overflow),
        .CRD       (CRD),
        .Add       (Add),
        .Drop      (Drop),
        .FifoReset (FifoReset),
        .Offset    (Offset),
        .ErrCount  (ErrCount),
        .Locked    (Locked)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Enable = 1'b0; Early = 1'b0; Late = 1'b0;
        Underflow = 1'b0; Overflow = 1'b0;
        #12;
        checks++;
        if ({CRD, Add, Drop, FifoReset, Offset, ErrCount, Locked} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {CRD, Add, Drop, FifoReset, Offset, ErrCount, Locked});
        end
        tick();
        Reset = 1'b0;
        tick();
        checks++;
        if ({CRD, FifoReset} !== 2'b00) begin
            errors++;
            $display("FAIL idle_disabled: CRD/FifoReset=%b required 00", {CRD, FifoReset});
        end
    endtask

    task automatic test_startup();
        int hi;
        Enable = 1'b1;
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (FifoReset === 1'b1 && CRD === 1'b0) hi++;
        end
        checks++;
        if (hi !== 8) begin
            errors++;
            $display("FAIL resync_len: FifoReset-only cycles=%0d required 8", hi);
        end
        tick();
        checks++;
        if ({FifoReset, CRD, Offset, Locked} !== {1'b0, 1'b1, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL track_entry: FifoReset=%b CRD=%b Offset=%0d Locked=%b required 0 1 0 0",
                     FifoReset, CRD, Offset, Locked);
        end
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 15 || i == 16) begin
                checks++;
                if (Locked !== (i == 16)) begin
                    errors++;
                    $display("FAIL lock_time: cycle %0d Locked=%b required %b", i, Locked, i == 16);
                end
            end
        end
    endtask

    task automatic test_add();
        int bad;
        bad = 0;
        Early = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (Add !== (i == 6 || i == 15) || Drop !== 1'b0 || CRD !== 1'b1) bad++;
            if (i == 6) begin
                checks++;
                if (Offset !== 8'd1) begin
                    errors++;
                    $display("FAIL add_offset: Offset=%0d required 1", Offset);
                end
            end
        end
        Early = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL add_timing: %0d bad cycles required 0", bad);
        end
        checks++;
        if ({Offset, Locked} !== {8'd2, 1'b0}) begin
            errors++;
            $display("FAIL add_second: Offset=%0d Locked=%b required 2 0", Offset, Locked);
        end
    endtask

    task automatic test_quiet();
        int bad;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (Locked !== 1'b1) begin
            errors++;
            $display("FAIL relock: Locked=%b required 1", Locked);
        end
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            Early = (i < 20) ? (i % 2 == 0) : 1'b1;
            Late  = (i < 20) ? (i % 2 == 1) : 1'b1;
            tick();
            if (Add !== 1'b0 || Drop !== 1'b0 || Locked !== 1'b1) bad++;
        end
        Early = 1'b0; Late = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL quiet_pattern: %0d cycles with Add/Drop or lost lock, required 0", bad);
        end
    endtask

    task automatic test_drop_sat();
        int drops, last_drop, bad;
        drops = 0; last_drop = 0; bad = 0;
        Late = 1'b1;
        for (int i = 1; i <= 267; i++) begin
            tick();
            if (Drop === 1'b1) begin
                drops++;
                last_drop = i;
            end
            if (Add !== 1'b0) bad++;
        end
        checks++;
        if (drops !== 22 || last_drop !== 195 || bad !== 0) begin
            errors++;
            $display("FAIL drop_count: drops=%0d last=%0d adds=%0d required 22 195 0", drops, last_drop, bad);
        end
        checks++;
        if (Offset !== 8'hEC) begin
            errors++;
            $display("FAIL drop_sat: Offset=%0d required -20", $signed(Offset));
        end
        Late = 1'b0; Early = 1'b1;
        bad = 0;
        for (int i = 268; i <= 276; i++) begin
            tick();
            if (Add !== (i == 276)) bad++;
        end
        Early = 1'b0;
        checks++;
        if (bad !== 0 || Offset !== 8'hED) begin
            errors++;
            $display("FAIL sat_hold: bad=%0d Offset=%0d required 0 -19", bad, $signed(Offset));
        end
    endtask

    task automatic test_error();
        int hi;
        for (int i = 0; i < 3; i++) tick();
        Early = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        Overflow = 1'b1;
        tick();
        Overflow = 1'b0; Early = 1'b0;
        checks++;
        if ({Add, FifoReset, CRD, ErrCount, Locked} !== {1'b0, 1'b1, 1'b0, 8'd1, 1'b0}) begin
            errors++;
            $display("FAIL err_entry: Add=%b FifoReset=%b CRD=%b ErrCount=%0d Locked=%b required 0 1 0 1 0",
                     Add, FifoReset, CRD, ErrCount, Locked);
        end
`ifdef AD_FIFO_CTRL_STICKY_ERR_EN
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (FifoReset === 1'b1 && CRD === 1'b0) hi++;
        end
        checks++;
        if (hi !== 12) begin
            errors++;
            $display("FAIL fault_sticky: fault cycles=%0d required 12", hi);
        end
        Enable = 1'b0;
        tick();
        Enable = 1'b1;
        tick();
`endif
        checks++;
        if (Offset !== 8'd0) begin
            errors++;
            $display("FAIL err_offset: Offset=%0d required 0", $signed(Offset));
        end
        hi = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (FifoReset === 1'b1) hi++;
        end
        tick();
        checks++;
        if (hi !== 7 || FifoReset !== 1'b0 || CRD !== 1'b1) begin
            errors++;
            $display("FAIL err_resync: extra high=%0d FifoReset=%b CRD=%b required 7 0 1", hi, FifoReset, CRD);
        end
    endtask

    task automatic test_async_reset();
        int hi;
        Early = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        Early = 1'b0;
        checks++;
        if (Add !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_add: Add=%b required 1", Add);
        end
        #3;
        Reset = 1'b1;
        #1;
        checks++;
        if ({CRD, Add, Drop, FifoReset, Offset, ErrCount, Locked} !== 21'd0) begin
            errors++;
            $display("FAIL async_reset: got %b required all zero",
                     {CRD, Add, Drop, FifoReset, Offset, ErrCount, Locked});
        end
        tick();
        Reset = 1'b0;
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (FifoReset === 1'b1 && CRD === 1'b0) hi++;
        end
        tick();
        checks++;
        if (hi !== 8 || FifoReset !== 1'b0 || CRD !== 1'b1) begin
            errors++;
            $display("FAIL restart: resync=%0d FifoReset=%b CRD=%b required 8 0 1", hi, FifoReset, CRD);
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_add();
        test_quiet();
        test_drop_sat();
        test_error();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
